// File: rtl/or_pkg.sv
// ============================================================================
// Module : or_pkg
// Brief  : Shared width, all-ones constant and word type for the OR slice.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package or_pkg;

  localparam int OR_WIDTH = 32;

  localparam logic [OR_WIDTH-1:0] ALL_ONES = {OR_WIDTH{1'b1}};

  typedef logic [OR_WIDTH-1:0] word_t;

endpackage

`default_nettype wire

// File: rtl/or_32_bitwise_if.sv
// ============================================================================
// Module : or_32_bitwise_if
// Brief  : Operand/result valid-ready bundle for the OR functional slice.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface or_32_bitwise_if
  import or_pkg::*;
#(
  parameter int WIDTH = OR_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] o;
  logic             out_valid;
  logic             out_ready;
  logic             zero;
  logic             ones;

  // Producer/consumer side that feeds operands and drains results
  modport master (
    output a,
    output b,
    output in_valid,
    input  in_ready,
    input  o,
    input  out_valid,
    output out_ready,
    input  zero,
    input  ones
  );

  modport slave (
    input  a,
    input  b,
    input  in_valid,
    output in_ready,
    output o,
    output out_valid,
    input  out_ready,
    output zero,
    output ones
  );

endinterface

`default_nettype wire

// File: rtl/or_flag_gen.sv
// ============================================================================
// Module : or_flag_gen
// Brief  : Combinational zero / all-ones detector for a WIDTH-bit value.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module or_flag_gen
  import or_pkg::*;
#(
  parameter int WIDTH = OR_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  output logic             zero,
  output logic             ones
);

  assign zero = ~|value;
  assign ones = &value;

endmodule

`default_nettype wire

// File: rtl/or_32_bitwise.sv
// ============================================================================
// Module : or_32_bitwise
// Brief  : Registered WIDTH-bit bitwise OR with valid/ready on both sides and
//          zero / all-ones result flags. Optional macro OR_COMB_OUT_EN adds an
//          unregistered comb_o = a | b output port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module or_32_bitwise
  import or_pkg::*;
#(
  parameter int WIDTH = OR_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  or_32_bitwise_if.slave     bus
`ifdef OR_COMB_OUT_EN
  ,
  output logic [WIDTH-1:0]   comb_o
`endif
);

  logic [WIDTH-1:0] w_or;
  logic             w_zero;
  logic             w_ones;
  logic             w_in_ready;
  logic             w_accept;

  logic [WIDTH-1:0] r_o;
  logic             r_zero;
  logic             r_ones;
  logic             r_out_valid;

  assign w_or = bus.a | bus.b;

  or_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .value (w_or),
    .zero  (w_zero),
    .ones  (w_ones)
  );

  // Single-entry output stage: free when empty or being drained this cycle
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o         <= '0;
      r_zero      <= 1'b0;
      r_ones      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_o         <= w_or;
        r_zero      <= w_zero;
        r_ones      <= w_ones;
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        // Drained with nothing new: data and flags keep their last values
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.o         = r_o;
  assign bus.zero      = r_zero;
  assign bus.ones      = r_ones;
  assign bus.out_valid = r_out_valid;

`ifdef OR_COMB_OUT_EN
  assign comb_o = w_or;
`endif

endmodule

`default_nettype wire

// File: tb/tb_or_32_bitwise.sv
// ============================================================================
// Module : tb_or_32_bitwise
// Brief  : Directed, table-driven self-checking bench for or_32_bitwise.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_or_32_bitwise;
  import or_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_o;
    logic        exp_zero;
    logic        exp_ones;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  or_32_bitwise_if #(.WIDTH(32)) bus ();

`ifdef OR_COMB_OUT_EN
  logic [31:0] comb_o;
`endif

  or_32_bitwise #(
    .WIDTH (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus)
`ifdef OR_COMB_OUT_EN
    ,
    .comb_o (comb_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic check_out(input string name, input logic [31:0] eo, input logic ez, input logic e1, input logic ev);
    check({name, ".o"},         bus.o,                 eo);
    check({name, ".zero"},      {31'd0, bus.zero},      {31'd0, ez});
    check({name, ".ones"},      {31'd0, bus.ones},      {31'd0, e1});
    check({name, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, ev});
  endtask

  vec_t vecs [7];

  initial begin
    n_pass  = 0;
    n_total = 0;

    vecs[0] = '{32'hFFFF0FF0, 32'h00FF0F0F, 32'hFFFF0FFF, 1'b0, 1'b0};
    vecs[1] = '{32'h00000F00, 32'hFFFF0F00, 32'hFFFF0F00, 1'b0, 1'b0};
    vecs[2] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[3] = '{32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[4] = '{32'h80000000, 32'h00000001, 32'h80000001, 1'b0, 1'b0};
    vecs[5] = '{32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[6] = '{32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1'b0};

    rst_n         = 1'b0;
    bus.a         = 32'h12340000;
    bus.b         = 32'h00005678;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    #3;
    check_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef OR_COMB_OUT_EN
    check("comb_o_in_reset", comb_o, 32'h12345678);
`endif

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream: each vector accepted on consecutive edges
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.a         = vecs[i].a;
      bus.b         = vecs[i].b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
`ifdef OR_COMB_OUT_EN
      #1;
      check($sformatf("comb_o[%0d]", i), comb_o, vecs[i].exp_o);
`endif
      @(posedge clk);
      #1;
      check_out($sformatf("vec[%0d]", i), vecs[i].exp_o, vecs[i].exp_zero, vecs[i].exp_ones, 1'b1);
    end

    // Drain with no new operand: valid drops, data and flags hold
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 32'h0;
    bus.b        = 32'h0;
    @(posedge clk);
    #1;
    check_out("drain", 32'h00000001, 1'b0, 1'b0, 1'b0);

    // Idle cycle with operands present but not valid: nothing changes
    @(posedge clk);
    #1;
    check_out("idle", 32'h00000001, 1'b0, 1'b0, 1'b0);

    // Backpressure
    @(negedge clk);
    bus.a        = 32'h0000000F;
    bus.b        = 32'h000000F0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_out("bp.load", 32'h000000FF, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.a         = 32'h11110000;
    bus.b         = 32'h00002222;
    #1;
    check("bp.in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("bp.hold[%0d]", c), 32'h000000FF, 1'b0, 1'b0, 1'b1);
      check($sformatf("bp.in_ready[%0d]", c), {31'd0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("bp.in_ready_release", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check_out("bp.accept", 32'h11112222, 1'b0, 1'b0, 1'b1);

    // Async reset while a result is pending and a new handshake is offered
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.a         = 32'hFFFF0000;
    bus.b         = 32'h0000FFFF;
    bus.in_valid  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_hold", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    #1;
    check("post_reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check_out("post_reset", 32'h0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/or_32_bitwise.md
Name: or_32_bitwise

Overview:
- Registered 32-bit bitwise OR unit: o = a | b per bit, no carries, no bit interaction.
- Sits in the RISC-V ALU datapath as the OR/ORI functional slice.
- Uses valid/ready handshakes on the operand side and the result side.
- Also produces zero and all-ones result flags for downstream condition logic.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 1; all behaviour below scales per bit.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  operands a/b are valid this cycle.
- in_ready  output  1  unit can accept operands this cycle.
- o  output  WIDTH  registered result a | b.
- out_valid  output  1  o and the flags hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- zero  output  1  registered flag: o == 0.
- ones  output  1  registered flag: o == all ones.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n low, any time, asynchronously): o = 0, zero = 0, ones = 0, out_valid = 0.
- Reset mid-operation discards any pending result; no result is produced for a handshake cut off by reset.
- in_ready = !out_valid || out_ready. It is combinational and has no dependency on in_valid.
- Accept condition: in_valid && in_ready at the rising edge. On accept:
  - o <= a | b (bitwise, all WIDTH bits).
  - zero <= ((a | b) == 0).
  - ones <= ((a | b) == {WIDTH{1'b1}}).
  - out_valid <= 1.
- Latency: exactly 1 cycle from accept to out_valid. Throughput: 1 result per cycle when out_ready is held high.
- Result consumed (out_valid && out_ready) with no simultaneous accept: out_valid <= 0. o and the flags hold their last values.
- Simultaneous consume and accept in the same cycle: the new result replaces the old one and out_valid stays 1. No bubble.
- Backpressure (out_valid = 1, out_ready = 0):
  - o, zero, ones and out_valid hold stable.
  - in_ready = 0; operands are ignored.
- in_valid = 0: registers hold, except the out_valid clear described above.
- a/b values while not accepted have no effect.
- No X propagation on outputs after reset.

Optional Feature:
- Macro: OR_COMB_OUT_EN.
- When defined: extra output port comb_o (WIDTH) = a | b, purely combinational and independent of clk, rst_n and the handshakes.
- When not defined: the comb_o port does not exist. All other behaviour is identical in both builds.

Decomposition:
- Shared package or_pkg holds:
  - the OR_WIDTH constant (32);
  - the ALL_ONES constant;
  - a typedef word_t, logic [OR_WIDTH-1:0].
- One natural sub-module, or_flag_gen: combinational; takes a WIDTH value and outputs zero and ones. It is instantiated on the a | b path ahead of the registers.

Test Plan:
- Reset: assert rst_n low mid-stream with out_valid = 1 -> immediately o = 0, zero = 0, ones = 0, out_valid = 0; in_ready = 1 after release.
- Basic: a = 0xFFFF0FF0, b = 0x00FF0F0F, in_valid = 1, out_ready = 1 -> next cycle o = 0xFFFF0FFF, out_valid = 1, zero = 0, ones = 0. Then a = 0x00000F00, b = 0xFFFF0F00 -> o = 0xFFFF0F00.
- Flags:
  - a = 0, b = 0 -> o = 0x00000000, zero = 1, ones = 0.
  - a = 0xFFFF0000, b = 0x0000FFFF -> o = 0xFFFFFFFF, zero = 0, ones = 1.
- Backpressure: result pending with out_ready = 0 for 3 cycles while in_valid = 1 with new operands -> in_ready = 0 and o is unchanged throughout. Then out_ready = 1 -> the new operands are accepted that same cycle and appear 1 cycle later.
- Streaming: 4 back-to-back operand pairs with out_ready held at 1 -> 4 consecutive cycles of out_valid = 1 with results in order and no bubbles.
- OR_COMB_OUT_EN build: a = 0x12340000, b = 0x00005678 -> comb_o = 0x12345678 in the same cycle, including while rst_n is low.
